// File: rtl/lanectrl_pause_sync_mc.sv
// rtl/lanectrl_pause_sync_mc.sv - per-lane HS_IO clock-pause synchroniser with minimum pause width and gap
// Optional per-lane stretch statistics are enabled by LANECTRL_PAUSE_SYNC_STATS_EN.
module lanectrl_pause_sync_mc #(
   parameter int NUM_LANES        = 4,
   parameter int SYNC_STAGES      = 2,
   parameter int MIN_PAUSE_CYCLES = 2,
   parameter int MIN_GAP_CYCLES   = 1,
   parameter int OUT_FALL_EDGE    = 0
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [NUM_LANES-1:0]   HS_IO_CLK_PAUSE,
`ifdef LANECTRL_PAUSE_SYNC_STATS_EN
   input  logic                   STAT_CLR,
   output logic [NUM_LANES*8-1:0] PAUSE_STRETCH_CNT,
`endif
   output logic [NUM_LANES-1:0]   HS_IO_CLK_PAUSE_SYNC,
   output logic                   PAUSE_ANY
);

   localparam int CW = $clog2(MIN_PAUSE_CYCLES + 1);
   localparam int GW = (MIN_GAP_CYCLES > 0) ? $clog2(MIN_GAP_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      state_t                 state_q, state_d;
      logic [CW-1:0]          cnt_q, cnt_d;
      logic [GW-1:0]          gcnt_q, gcnt_d;
      logic                   pend_q, pend_d;
      logic                   out_q, out_d;
      logic                   str_q, str_d;
      logic                   hold_exit;

      assign s = sync_q[SYNC_STAGES-1];

      always_ff @(posedge CLK or posedge RESET) begin
         if (RESET) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            pend_q  <= 1'b0;
            out_q   <= 1'b0;
            str_q   <= 1'b0;
         end else begin
            sync_q[0] <= HS_IO_CLK_PAUSE[g];
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            str_q   <= str_d;
         end
      end

      always_comb begin
         state_d   = state_q;
         cnt_d     = cnt_q;
         gcnt_d    = gcnt_q;
         pend_d    = pend_q;
         out_d     = out_q;
         str_d     = str_q;
         hold_exit = 1'b0;
         case (state_q)
            IDLE: begin
               if (s) begin
                  state_d = HOLD;
                  cnt_d   = CW'(1);
                  out_d   = 1'b1;
                  str_d   = 1'b0;
               end
            end
            HOLD: begin
               if (!s && cnt_q >= CW'(MIN_PAUSE_CYCLES)) begin
                  hold_exit = 1'b1;
                  out_d     = 1'b0;
                  cnt_d     = '0;
                  pend_d    = 1'b0;
                  if (MIN_GAP_CYCLES > 0) begin
                     state_d = GAP;
                     gcnt_d  = GW'(1);
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  if (cnt_q < CW'(MIN_PAUSE_CYCLES)) cnt_d = cnt_q + CW'(1);
                  // out is still high while the synced request has already gone low
                  if (!s) str_d = 1'b1;
               end
            end
            GAP: begin
               if (gcnt_q >= GW'(MIN_GAP_CYCLES)) begin
                  gcnt_d = '0;
                  pend_d = 1'b0;
                  if (s || pend_q) begin
                     state_d = HOLD;
                     cnt_d   = CW'(1);
                     out_d   = 1'b1;
                     str_d   = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  gcnt_d = gcnt_q + GW'(1);
                  // s is low on GAP entry, so any high s here is a new request
                  if (s) pend_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (OUT_FALL_EDGE != 0) begin : g_fall
         logic fe_q;
         always_ff @(negedge CLK or posedge RESET) begin
            if (RESET) fe_q <= 1'b0;
            else       fe_q <= out_q;
         end
         assign HS_IO_CLK_PAUSE_SYNC[g] = fe_q;
      end else begin : g_rise
         assign HS_IO_CLK_PAUSE_SYNC[g] = out_q;
      end

`ifdef LANECTRL_PAUSE_SYNC_STATS_EN
      logic [7:0] stat_q;
      always_ff @(posedge CLK or posedge RESET) begin
         if (RESET)                                        stat_q <= '0;
         else if (STAT_CLR)                                stat_q <= '0;
         else if (hold_exit && str_q && stat_q != 8'hff)   stat_q <= stat_q + 8'd1;
      end
      assign PAUSE_STRETCH_CNT[8*g +: 8] = stat_q;
`endif
   end

   assign PAUSE_ANY = |HS_IO_CLK_PAUSE_SYNC;

endmodule
